pipe_hazard_ctrl: RTL and testbench

Central pipeline control unit for the five-stage core. Each cycle it decides stall and bubble for the F/D/E/M/W pipeline registers from load-use hazards, branch/jump redirects resolved in E, and data-memory wait states. It tracks memory waits with a timeout FSM and keeps saturating performance counters. All pipeline registers take their stall and bubble inputs from this block only.

---
 rtl/pipe_hazard_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control unit for the five-stage core.
// Resolves memory wait states, E-stage redirects and load-use hazards into
// per-stage stall/bubble controls, supervises data-memory waits with a
// timeout FSM and maintains saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       regD_rs1,
    input  logic [4:0]       regD_rs2,
    input  logic             regD_use_rs1,
    input  logic             regD_use_rs2,
    input  logic [4:0]       regE_wb_rd,
    input  logic             regE_wb_reg_wen,
    input  logic             regE_is_load,
    input  logic             regE_branch_jump,
    input  logic             regM_mem_req,
    input  logic             dmem_ready,
    output logic             f_stall,
    output logic             d_stall,
    output logic             e_stall,
    output logic             m_stall,
    output logic             d_bubble,
    output logic             e_bubble,
    output logic             w_bubble,
    output logic [1:0]       ctrl_state,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wait counter only has to reach MEM_TIMEOUT.
    localparam int unsigned WCNT_W = (MEM_TIMEOUT < 32'd2) ? 1 : $clog2(MEM_TIMEOUT + 32'd1);
    // Value of wcnt during the busy cycle that completes the timeout window.
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 32'd1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic mem_busy_s;
    logic redirect_s;
    logic load_use_s;
    logic in_err_s;
    logic flush_act_s;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Raw hazard conditions derived from the D/E/M stage fields.
    always_comb begin
        mem_busy_s = regM_mem_req & ~dmem_ready;
        redirect_s = regE_branch_jump;
        load_use_s = regE_is_load & regE_wb_reg_wen & (regE_wb_rd != 5'd0) &
                     (((regE_wb_rd == regD_rs1) & regD_use_rs1) |
                      ((regE_wb_rd == regD_rs2) & regD_use_rs2));
        // Any encoding other than RUN/MEM_WAIT is treated as the error state.
        in_err_s   = (state_q != ST_RUN) && (state_q != ST_MEM_WAIT);
    end

    // Prioritised stall/bubble decode: error/busy > redirect > load-use.
    always_comb begin
        f_stall     = 1'b0;
        d_stall     = 1'b0;
        e_stall     = 1'b0;
        m_stall     = 1'b0;
        d_bubble    = 1'b0;
        e_bubble    = 1'b0;
        w_bubble    = 1'b0;
        flush_act_s = 1'b0;
        if (rst) begin
            f_stall = 1'b0;
        end else if (in_err_s || mem_busy_s) begin
            // Freeze F..M; W gets a NOP so the held M instruction commits once.
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_stall  = 1'b1;
            m_stall  = 1'b1;
            w_bubble = 1'b1;
        end else if (redirect_s) begin
            // Squash the two wrong-path instructions behind the redirect.
            d_bubble    = 1'b1;
            e_bubble    = 1'b1;
            flush_act_s = 1'b1;
        end else if (load_use_s) begin
            // Hold the consumer in D and insert a NOP into E.
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
        end else begin
            flush_act_s = 1'b0;
        end
    end

    // Memory-wait FSM, timeout flag and performance counter next-state.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (rst) begin
            state_d     = ST_RUN;
            wcnt_d      = '0;
            err_d       = 1'b0;
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_busy_s) begin
                        wcnt_d = WCNT_W'(1);
                        if (MEM_TIMEOUT <= 32'd1) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_MEM_WAIT;
                        end
                    end else begin
                        wcnt_d = '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_busy_s) begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                        if (wcnt_q == WCNT_LAST) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_MEM_WAIT;
                        end
                    end else begin
                        state_d = ST_RUN;
                        wcnt_d  = '0;
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end
                default: begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end
            endcase
            // Counters are frozen once the block has entered the error state.
            if (!in_err_s && f_stall) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (!in_err_s && flush_act_s) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // State, wait counter, error flag and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Registered status outputs.
    always_comb begin
        ctrl_state      = state_q;
        mem_timeout_err = err_q;
        stall_cnt       = stall_cnt_q;
        flush_cnt       = flush_cnt_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a stimulus process drives each
// cycle, asks a behavioural model for the expected outputs and queues them;
// a monitor process pops and compares on every falling edge.
module tb_pipe_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [4:0] regD_rs1, regD_rs2, regE_wb_rd;
    logic regD_use_rs1, regD_use_rs2, regE_wb_reg_wen, regE_is_load;
    logic regE_branch_jump, regM_mem_req, dmem_ready;
    logic f_stall, d_stall, e_stall, m_stall, d_bubble, e_bubble, w_bubble;
    logic [1:0] ctrl_state;
    logic mem_timeout_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .regD_rs1(regD_rs1), .regD_rs2(regD_rs2),
        .regD_use_rs1(regD_use_rs1), .regD_use_rs2(regD_use_rs2),
        .regE_wb_rd(regE_wb_rd), .regE_wb_reg_wen(regE_wb_reg_wen),
        .regE_is_load(regE_is_load), .regE_branch_jump(regE_branch_jump),
        .regM_mem_req(regM_mem_req), .dmem_ready(dmem_ready),
        .f_stall(f_stall), .d_stall(d_stall), .e_stall(e_stall), .m_stall(m_stall),
        .d_bubble(d_bubble), .e_bubble(e_bubble), .w_bubble(w_bubble),
        .ctrl_state(ctrl_state), .mem_timeout_err(mem_timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic [6:0] sb;   // {f,d,e,m stall, d,e,w bubble}
        int         st;
        int         err;
        int         sc;
        int         fc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Behavioural model: consecutive busy cycles, error flag, counters.
    int m_wait = 0;
    int m_err  = 0;
    int m_sc   = 0;
    int m_fc   = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, queue the expected response, advance the model.
    task automatic cycle(input logic r, input logic ld, input logic wen,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic br,
                         input logic req, input logic rdy);
        exp_t e;
        logic busy, lu;
        rst = r; regE_is_load = ld; regE_wb_reg_wen = wen; regE_wb_rd = rd;
        regD_rs1 = rs1; regD_rs2 = rs2; regD_use_rs1 = u1; regD_use_rs2 = u2;
        regE_branch_jump = br; regM_mem_req = req; dmem_ready = rdy;
        busy = req & ~rdy;
        lu = ld & wen & (rd != 5'd0) & (((rd == rs1) & u1) | ((rd == rs2) & u2));
        if (r)                      e.sb = 7'b0000000;
        else if (m_err != 0 || busy) e.sb = 7'b1111001;
        else if (br)                e.sb = 7'b0000110;
        else if (lu)                e.sb = 7'b1100010;
        else                        e.sb = 7'b0000000;
        e.st  = (m_err != 0) ? 2 : ((m_wait > 0) ? 1 : 0);
        e.err = m_err;
        e.sc  = m_sc;
        e.fc  = m_fc;
        exp_q.push_back(e);
        if (r) begin
            m_wait = 0; m_err = 0; m_sc = 0; m_fc = 0;
        end else if (m_err == 0) begin
            if (e.sb[6] && m_sc < CMAX) m_sc++;
            if (!busy && br && m_fc < CMAX) m_fc++;
            if (busy) begin
                m_wait++;
                if (m_wait == TO) m_err = 1;
            end else begin
                m_wait = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare queued expectations against the DUT mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("f_stall",  int'(f_stall),  int'(e.sb[6]));
            check("d_stall",  int'(d_stall),  int'(e.sb[5]));
            check("e_stall",  int'(e.sb[4]) == 0 ? int'(e_stall) : int'(e_stall), int'(e.sb[4]));
            check("m_stall",  int'(m_stall),  int'(e.sb[3]));
            check("d_bubble", int'(d_bubble), int'(e.sb[2]));
            check("e_bubble", int'(e_bubble), int'(e.sb[1]));
            check("w_bubble", int'(w_bubble), int'(e.sb[0]));
            check("ctrl_state", int'(ctrl_state), e.st);
            check("mem_timeout_err", int'(mem_timeout_err), e.err);
            check("stall_cnt", int'(stall_cnt), e.sc);
            check("flush_cnt", int'(flush_cnt), e.fc);
        end
    end

    initial begin
        rst = 1'b1; regD_rs1 = '0; regD_rs2 = '0; regE_wb_rd = '0;
        regD_use_rs1 = 1'b0; regD_use_rs2 = 1'b0; regE_wb_reg_wen = 1'b0;
        regE_is_load = 1'b0; regE_branch_jump = 1'b0; regM_mem_req = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        do_reset();
        idle(1);
        // Load-use on rs1, then the same with x0 as destination.
        cycle(0, 1, 1, 5, 5, 0, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        // Load-use on rs2 only, and an unused matching rs2.
        cycle(0, 1, 1, 7, 1, 7, 1, 1, 0, 0, 0);
        cycle(0, 1, 1, 7, 1, 7, 1, 0, 0, 0, 0);
        // Redirect together with load-use.
        cycle(0, 1, 1, 5, 5, 0, 1, 0, 1, 0, 0);
        idle(2);
        // Single-cycle memory access, then a 3-cycle wait.
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);
        // Redirect held through a 2-cycle wait.
        do_reset();
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle(2);
        // Wait of TO-1 cycles recovers without error.
        do_reset();
        for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        // Timeout, persistence in ERR, then one-cycle reset.
        for (int i = 0; i < TO + 2; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 3, 3, 0, 1, 0, 1, 1, 1);
        do_reset();
        idle(2);
        // Stall 20 cycles through load-use to saturate stall_cnt; 20 redirects.
        for (int i = 0; i < 20; i++) cycle(0, 1, 1, 9, 9, 9, 1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        // Randomised traffic with small register ranges to provoke hazards.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic r, ld, wen, u1, u2, br, req, rdy;
            logic [4:0] rd, rs1, rs2;
            r   = ($urandom_range(0, 99) < 2);
            ld  = $urandom_range(0, 1);
            wen = ($urandom_range(0, 3) != 0);
            rd  = 5'($urandom_range(0, 3));
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            u1  = $urandom_range(0, 1);
            u2  = $urandom_range(0, 1);
            br  = ($urandom_range(0, 4) == 0);
            req = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            cycle(r, ld, wen, rd, rs1, rs2, u1, u2, br, req, rdy);
        end
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
